// File: rtl/tx_slice_arbiter.sv
// Round-robin transmit arbiter for four slice-gated queues, with a
// microsecond transmission timeout. All outputs are registered.
//
//   state | meaning
//   IDLE  | no transmission; pick next eligible queue round-robin
//   START | one-cycle tx_start pulse for the granted queue
//   BUSY  | transmission in flight; wait for tx_done or timeout
module tx_slice_arbiter #(
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tsf_pulse_1M,
  input  logic             slice_en0,
  input  logic             slice_en1,
  input  logic             slice_en2,
  input  logic             slice_en3,
  input  logic [3:0]       queue_req,
  input  logic             tx_done,
  input  logic [TMO_W-1:0] timeout_us,
  output logic [3:0]       grant,
  output logic [1:0]       grant_idx,
  output logic             tx_start,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [3:0]       eligible;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic [TMO_W-1:0] tmo_cnt_nxt;
  logic             tmo_hit;

  assign eligible = queue_req & {slice_en3, slice_en2, slice_en1, slice_en0};

  // Search starts one past the last grant; offset 4 wraps back to it.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = grant_idx_q;
    cand       = grant_idx_q;
    for (int k = 1; k <= 4; k++) begin
      cand = grant_idx_q + 2'(k);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Compare against the post-increment count so the abort lands on the
  // cycle right after the terminal microsecond pulse.
  always_comb begin
    tmo_cnt_nxt = tmo_cnt_q;
    if (tsf_pulse_1M && !(&tmo_cnt_q)) begin
      tmo_cnt_nxt = tmo_cnt_q + TMO_W'(1);
    end
    tmo_hit = (timeout_us != '0) && (tmo_cnt_nxt == timeout_us);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    tx_start_d    = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = START;
          grant_d     = 4'b0001 << pick_idx;
          grant_idx_d = pick_idx;
          tx_start_d  = 1'b1;
          busy_d      = 1'b1;
          tmo_cnt_d   = '0;
        end
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        tmo_cnt_d = tmo_cnt_nxt;
        if (tx_done) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d       = IDLE;
          grant_d       = 4'b0000;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd3;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_q));

endmodule

// File: tb/tb_tx_slice_arbiter.sv
// Scoreboard bench for tx_slice_arbiter: directed stimulus pushes expected
// tx_start / timeout_err events, a negedge monitor pops and compares them.
module tb_tx_slice_arbiter;

  localparam int TMO_W = 20;

  logic             clk;
  logic             rstn;
  logic             tsf_pulse_1M;
  logic             slice_en0, slice_en1, slice_en2, slice_en3;
  logic [3:0]       queue_req;
  logic             tx_done;
  logic [TMO_W-1:0] timeout_us;
  logic [3:0]       grant;
  logic [1:0]       grant_idx;
  logic             tx_start;
  logic             busy;
  logic             timeout_err;

  typedef struct packed {
    logic       is_tmo;
    logic [3:0] grant;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  tx_slice_arbiter #(.TMO_W(TMO_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tsf_pulse_1M (tsf_pulse_1M),
    .slice_en0    (slice_en0),
    .slice_en1    (slice_en1),
    .slice_en2    (slice_en2),
    .slice_en3    (slice_en3),
    .queue_req    (queue_req),
    .tx_done      (tx_done),
    .timeout_us   (timeout_us),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .tx_start     (tx_start),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [3:0] en);
    {slice_en3, slice_en2, slice_en1, slice_en0} = en;
  endtask

  task automatic expect_start(input logic [3:0] g, input logic [1:0] idx);
    exp_t e;
    e.is_tmo = 1'b0;
    e.grant  = g;
    e.idx    = idx;
    exp_q.push_back(e);
  endtask

  task automatic expect_tmo();
    exp_t e;
    e.is_tmo = 1'b1;
    e.grant  = 4'b0000;
    e.idx    = 2'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: every tx_start or timeout_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn) begin
      check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      if (tx_start || timeout_err) begin
        check("event_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_kind_is_tmo", {31'd0, timeout_err}, {31'd0, e.is_tmo});
          check("event_tx_start", {31'd0, tx_start}, {31'd0, ~e.is_tmo});
          check("event_grant", {28'd0, grant}, {28'd0, e.grant});
          check("event_busy", {31'd0, busy}, {31'd0, ~e.is_tmo});
          if (!e.is_tmo) check("event_grant_idx", {30'd0, grant_idx}, {30'd0, e.idx});
        end
      end
    end
  end

  initial begin
    rstn         = 1'b0;
    tsf_pulse_1M = 1'b0;
    set_en(4'b0000);
    queue_req    = 4'b0000;
    tx_done      = 1'b0;
    timeout_us   = '0;

    #12;
    check("rst_grant", {28'd0, grant}, 32'h0);
    check("rst_grant_idx", {30'd0, grant_idx}, 32'd3);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    step();
    rstn = 1'b1;
    step();

    // Round robin: queue 0 first after reset, then queue 2.
    queue_req = 4'b0101;
    set_en(4'b1111);
    expect_start(4'b0001, 2'd0);
    step();
    check("rr1_tx_start_latency", {31'd0, tx_start}, 32'd1);
    step();
    check("rr1_tx_start_one_cycle", {31'd0, tx_start}, 32'd0);
    check("rr1_busy", {31'd0, busy}, 32'd1);
    check("rr1_grant_held", {28'd0, grant}, 32'h1);
    tx_done = 1'b1;
    expect_start(4'b0100, 2'd2);
    step();
    tx_done = 1'b0;
    check("rr1_done_grant", {28'd0, grant}, 32'h0);
    check("rr1_done_busy", {31'd0, busy}, 32'd0);
    check("rr1_done_idx_kept", {30'd0, grant_idx}, 32'd0);
    check("rr1_no_start_on_busy_fall", {31'd0, tx_start}, 32'd0);
    step();
    check("rr2_tx_start", {31'd0, tx_start}, 32'd1);
    check("rr2_grant", {28'd0, grant}, 32'h4);
    step();
    queue_req = 4'b0000;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    check("rr2_done_busy", {31'd0, busy}, 32'd0);

    // Slice gating: only queue 2 enabled; later enable changes don't matter.
    queue_req = 4'b1111;
    set_en(4'b0100);
    expect_start(4'b0100, 2'd2);
    step();
    check("slice_tx_start", {31'd0, tx_start}, 32'd1);
    tx_done = 1'b1;
    set_en(4'b0000);
    step();
    tx_done = 1'b0;
    check("slice_done_in_start_ignored", {31'd0, busy}, 32'd1);
    queue_req = 4'b1010;
    set_en(4'b1011);
    for (int i = 0; i < 3; i++) begin
      step();
      check("slice_grant_held", {28'd0, grant}, 32'h4);
      check("slice_idx_held", {30'd0, grant_idx}, 32'd2);
      check("slice_busy_held", {31'd0, busy}, 32'd1);
    end
    queue_req = 4'b0000;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    check("slice_done_busy", {31'd0, busy}, 32'd0);
    set_en(4'b1111);

    // Timeout of 5 us with no tx_done.
    timeout_us = 20'd5;
    queue_req  = 4'b0001;
    expect_start(4'b0001, 2'd0);
    step();
    queue_req = 4'b0000;
    step();
    for (int i = 1; i <= 5; i++) begin
      tsf_pulse_1M = 1'b1;
      if (i == 5) expect_tmo();
      step();
      tsf_pulse_1M = 1'b0;
      if (i < 5) begin
        check("tmo_no_err_early", {31'd0, timeout_err}, 32'd0);
        check("tmo_busy_early", {31'd0, busy}, 32'd1);
        step();
      end
    end
    check("tmo_err_pulse", {31'd0, timeout_err}, 32'd1);
    check("tmo_grant_cleared", {28'd0, grant}, 32'h0);
    check("tmo_busy_cleared", {31'd0, busy}, 32'd0);
    step();
    check("tmo_err_one_cycle", {31'd0, timeout_err}, 32'd0);

    // tx_done coincident with the timeout condition wins.
    queue_req = 4'b0010;
    expect_start(4'b0010, 2'd1);
    step();
    queue_req = 4'b0000;
    step();
    for (int i = 1; i <= 5; i++) begin
      tsf_pulse_1M = 1'b1;
      if (i == 5) tx_done = 1'b1;
      step();
      tsf_pulse_1M = 1'b0;
      tx_done      = 1'b0;
      if (i < 5) step();
    end
    check("tie_no_err", {31'd0, timeout_err}, 32'd0);
    check("tie_busy_cleared", {31'd0, busy}, 32'd0);
    check("tie_grant_cleared", {28'd0, grant}, 32'h0);
    step();
    check("tie_no_err_later", {31'd0, timeout_err}, 32'd0);

    // Timeout disabled for 100 us, then enabled mid-transmission.
    timeout_us = '0;
    queue_req  = 4'b0100;
    expect_start(4'b0100, 2'd2);
    step();
    queue_req = 4'b0000;
    step();
    for (int i = 0; i < 100; i++) begin
      tsf_pulse_1M = 1'b1;
      step();
      tsf_pulse_1M = 1'b0;
      check("dis_busy", {31'd0, busy}, 32'd1);
      check("dis_no_err", {31'd0, timeout_err}, 32'd0);
      step();
      step();
      step();
    end
    timeout_us   = 20'd102;
    tsf_pulse_1M = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    check("live_tmo_101_busy", {31'd0, busy}, 32'd1);
    step();
    tsf_pulse_1M = 1'b1;
    expect_tmo();
    step();
    tsf_pulse_1M = 1'b0;
    check("live_tmo_102_err", {31'd0, timeout_err}, 32'd1);
    check("live_tmo_busy", {31'd0, busy}, 32'd0);
    timeout_us = '0;
    step();

    // Reset during BUSY aborts silently; then lowest eligible queue wins.
    queue_req = 4'b0010;
    expect_start(4'b0010, 2'd1);
    step();
    queue_req = 4'b0000;
    step();
    check("rstmid_grant_before", {28'd0, grant}, 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("rstmid_grant", {28'd0, grant}, 32'h0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_idx", {30'd0, grant_idx}, 32'd3);
    check("rstmid_tx_start", {31'd0, tx_start}, 32'd0);
    queue_req = 4'b1111;
    step();
    step();
    rstn = 1'b1;
    expect_start(4'b0001, 2'd0);
    step();
    check("post_rst_tx_start", {31'd0, tx_start}, 32'd1);
    check("post_rst_grant", {28'd0, grant}, 32'h1);
    queue_req = 4'b0000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;

    repeat (5) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_slice_arbiter.md
TX_SLICE_ARBITER -- requirements
Module: tx_slice_arbiter

Interface
REQ-001 Parameter: TMO_W, default 20, width of timeout_us and the internal microsecond timeout counter.
REQ-002 clk  input  1  single clock domain for all logic.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 tsf_pulse_1M  input  1  one-cycle pulse every 1 us.
REQ-005 slice_en0..slice_en3  input  1 each  per-queue slice enable from the slice generator; level.
REQ-006 queue_req  input  4  bit i = queue i has a frame pending; level.
REQ-007 tx_done  input  1  one-cycle pulse marking end of the granted transmission.
REQ-008 timeout_us  input  TMO_W  max transmission length in us; 0 disables timeout.
REQ-009 grant  output  4  one-hot granted queue; all-zero when idle.
REQ-010 grant_idx  output  2  index of current/last granted queue.
REQ-011 tx_start  output  1  one-cycle pulse starting a transmission.
REQ-012 busy  output  1  high from tx_start through completion.
REQ-013 timeout_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-014 Queue i is eligible only when queue_req[i]=1 and slice_en_i=1 in the same cycle.
REQ-015 The arbiter SHALL use the FSM states IDLE, START, BUSY; all outputs registered.
REQ-016 In IDLE, if any queue is eligible, the arbiter SHALL select one round-robin, searching from (last grant_idx + 1) mod 4 upward with wrap 3->0.
REQ-017 The arbiter SHALL enter START one cycle after eligibility is sampled in IDLE, with grant, grant_idx, tx_start=1 and busy=1 updated in that same cycle.
REQ-018 tx_start SHALL be high for exactly one cycle (START); the FSM SHALL move to BUSY on the next cycle.
REQ-019 grant and grant_idx SHALL be held constant from START until return to IDLE, irrespective of queue_req or slice_en changes.
REQ-020 A slice_en falling during START/BUSY SHALL NOT abort the transmission.
REQ-021 tx_done SHALL be sampled only in BUSY; tx_done in IDLE or START is ignored.
REQ-022 tx_done in BUSY SHALL take the FSM to IDLE next cycle, with grant=0 and busy=0 in that cycle; grant_idx retained.
REQ-023 A new grant SHALL NOT issue in the cycle busy falls; earliest tx_start is 2 cycles after the tx_done cycle.
REQ-024 The timeout counter SHALL clear on entry to START and increment on each tsf_pulse_1M while in BUSY, saturating at all-ones.
REQ-025 In BUSY, with timeout_us!=0, when the counter equals timeout_us the FSM SHALL go to IDLE, pulse timeout_err for one cycle, and clear grant and busy.
REQ-026 If tx_done and the timeout condition occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay 0.
REQ-027 timeout_us SHALL be sampled continuously; a change mid-transmission takes effect immediately.
REQ-028 Only one queue SHALL ever be granted; grant SHALL never have more than one bit set.

Reset
REQ-029 On rstn=0, asynchronously: FSM=IDLE, grant=0, grant_idx=3, tx_start=0, busy=0, timeout_err=0, timeout counter=0, so queue 0 has first priority after reset.
REQ-030 Reset asserted mid-transmission SHALL abort it with no tx_start or timeout_err pulse; operation resumes in IDLE the first clk edge after rstn rises.

Verification
REQ-031 After reset, queue_req=4'b0101, slice_en0..3=1 -> tx_start, grant=4'b0001, grant_idx=0 one cycle later; after tx_done, next grant=4'b0100.
REQ-032 queue_req=4'b1111, slice_en only slice_en2=1 -> grant=4'b0100 only; drop slice_en2 during BUSY -> grant held until tx_done.
REQ-033 timeout_us=5, no tx_done -> timeout_err pulse on the cycle after the 5th tsf_pulse_1M in BUSY; grant=0 and busy=0 there.
REQ-034 timeout_us=5, tx_done coincident with the timeout cycle -> normal completion, timeout_err=0.
REQ-035 timeout_us=0, no tx_done for 100 us -> busy stays 1, no timeout_err.
REQ-036 rstn pulsed low during BUSY with grant=4'b0010 -> immediate grant=0, busy=0, grant_idx=3; first post-reset grant goes to the lowest eligible index.
